// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Consumer end of the PLL lock interface. Synchronizes the raw, asynchronous
// PLL lock into the PLL output clock domain, waits for lock to be stable for
// a programmable time, holds reset for a few extra cycles, then releases a
// synchronously-deasserted system reset. Losing lock once stability has been
// established (HOLD or RUN) re-asserts reset and is recorded.
//
// Parameters:
//   SYNC_STAGES        flops on the pll_locked synchronizer (legal 2..4)
//   LOCK_STABLE_CYCLES consecutive lock-high cycles before HOLD (legal >= 1)
//   RESET_HOLD_CYCLES  extra reset cycles after lock is stable (legal >= 1)
//   LOSS_CNT_W         width of the saturating lock-loss counter
//
// Ports:
//   clk             in   PLL output clock, the only clock
//   rst_n           in   asynchronous active-low board/power-on reset
//   pll_locked      in   raw PLL lock, asynchronous to clk, may glitch
//   sys_rst_n       out  system reset, active-low; async assert, sync release
//   ready           out  high exactly while the sequencer is in RUN
//   lock_lost       out  sticky flag, set on any loss of lock in HOLD/RUN
//   lock_loss_count out  saturating count of lock losses in HOLD/RUN
//
// Build option:
//   PLL_RESET_SEQ_LOSS_STATS_EN  when defined, lock_lost/lock_loss_count are
//   implemented; when undefined both outputs are tied to 0 and no flag or
//   counter flops exist.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    // One down-counter serves both timed phases; size it for the longer one.
    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   run_q;

    // ------------------------------------------------------------------
    // Lock synchronizer. Nothing else may look at pll_locked directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer state register. run_q is a registered decode of the next
    // state, so sys_rst_n changes on the very edge the FSM enters or
    // leaves RUN, and asserts asynchronously with rst_n.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    cnt_d   = LOCK_LOAD;
                    state_d = STABLE;
                end
            end
            STABLE: begin
                // Any dropout restarts the whole stability window.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign sys_rst_n = run_q;
    assign ready     = run_q;

`ifdef PLL_RESET_SEQ_LOSS_STATS_EN
    // ------------------------------------------------------------------
    // Loss statistics. A dropout during STABLE is not a loss: stability
    // had not been established yet.
    // ------------------------------------------------------------------
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = LOSS_CNT_W'(1);

    logic                  loss_evt;
    logic                  lock_lost_q;
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    assign loss_evt = !lock_s && ((state_q == HOLD) || (state_q == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else if (loss_evt) begin
            lock_lost_q <= 1'b1;
            if (loss_cnt_q != '1) begin
                loss_cnt_q <= loss_cnt_q + LOSS_ONE;
            end
        end
    end

    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_lost       = 1'b0;
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Two sequencers share clock, reset and lock input: one with an 8-bit loss
// counter and one with a 2-bit counter, so saturation is exercised alongside
// the normal behaviour. Each clock edge is checked against a reference model
// that tracks how many consecutive synchronized-lock-high samples the
// sequencer has seen; a vector table and a few hand-written sequences add
// explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;

`ifdef PLL_RESET_SEQ_LOSS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sys_rst_n_a, ready_a, lock_lost_a;
    logic [7:0] count_a;
    logic       sys_rst_n_b, ready_b, lock_lost_b;
    logic [1:0] count_b;
    logic [15:0] act;

    int vectors    = 0;
    int miscompares = 0;

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES(RHC), .LOSS_CNT_W(8)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sys_rst_n(sys_rst_n_a), .ready(ready_a),
        .lock_lost(lock_lost_a), .lock_loss_count(count_a)
    );

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES(RHC), .LOSS_CNT_W(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sys_rst_n(sys_rst_n_b), .ready(ready_b),
        .lock_lost(lock_lost_b), .lock_loss_count(count_b)
    );

    assign act = {sys_rst_n_a, ready_a, lock_lost_a, count_a,
                  sys_rst_n_b, ready_b, lock_lost_b, count_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // run = consecutive edges on which the sequencer saw synchronized lock
    // high. Reset releases after 1+LSC+RHC such edges; a dropout is a loss
    // once at least 1+LSC have been seen (HOLD or RUN).
    bit hist [SYNC];
    int run;
    bit m_lost;
    int m_loss;

    function automatic void model_reset();
        for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
        run    = 0;
        m_lost = 1'b0;
        m_loss = 0;
    endfunction

    function automatic void model_edge(input bit lk);
        bit seen;
        seen = hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = lk;
        if (seen) begin
            if (run < 1000000) run++;
        end else begin
            if (run >= LSC + 1) begin
                m_lost = 1'b1;
                m_loss++;
            end
            run = 0;
        end
    endfunction

    function automatic logic [15:0] exp_of(input bit r, input bit lost, input int n);
        logic       l;
        logic [7:0] c8;
        logic [1:0] c2;
        l  = STATS ? lost : 1'b0;
        c8 = STATS ? 8'((n > 255) ? 255 : n) : 8'd0;
        c2 = STATS ? 2'((n > 3) ? 3 : n) : 2'd0;
        return {r, r, l, c8, r, r, l, c2};
    endfunction

    task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h required %h", nm, $time, got, req);
        end
    endtask

    task automatic step(input bit lk);
        pll_locked = lk;
        @(posedge clk);
        model_edge(lk);
        #1;
        cmp("model", act, exp_of(run >= 1 + LSC + RHC, m_lost, m_loss));
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_state", act, 16'h0000);
        rst_n = 1'b1;
    endtask

    // Pulse rst_n between edges; outputs must clear with no clock edge.
    task automatic async_pulse();
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst", act, 16'h0000);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit lk;
        int reps;
        bit exp_run;
        bit exp_lost;
        int exp_loss;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // Cold start: low through edge 13, high on edge 14.
        tbl[0] = '{1'b1, 14, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1,  1'b1, 1'b0, 0};
        // Five losses in RUN, each followed by a full relock.
        for (int k = 1; k <= 5; k++) begin
            tbl[4*k-2] = '{1'b0, 2,  1'b1, (k > 1), k - 1};
            tbl[4*k-1] = '{1'b0, 1,  1'b0, 1'b1,    k};
            tbl[4*k]   = '{1'b1, 14, 1'b0, 1'b1,    k};
            tbl[4*k+1] = '{1'b1, 1,  1'b1, 1'b1,    k};
        end

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        model_reset();

        do_reset();
        for (int i = 0; i < 22; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].lk);
            cmp($sformatf("tbl%0d", i), act,
                exp_of(tbl[i].exp_run, tbl[i].exp_lost, tbl[i].exp_loss));
        end

        // Glitch in STABLE: low at edge 5, high again from edge 6 -> rise at 20.
        do_reset();
        repeat (5) step(1'b1);
        step(1'b0);
        repeat (14) step(1'b1);
        cmp("glitch_low", act, exp_of(1'b0, 1'b0, 0));
        step(1'b1);
        cmp("glitch_rise", act, exp_of(1'b1, 1'b0, 0));

        // Loss in HOLD: dropout sampled at edge 10, seen in HOLD at edge 12.
        do_reset();
        repeat (10) step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        cmp("hold_loss", act, exp_of(1'b0, 1'b1, 1));
        repeat (12) step(1'b1);
        cmp("hold_relock_low", act, exp_of(1'b0, 1'b1, 1));
        step(1'b1);
        cmp("hold_relock_rise", act, exp_of(1'b1, 1'b1, 1));

        // Async reset mid-RUN, then a full relock from a zeroed synchronizer.
        async_pulse();
        repeat (14) step(1'b1);
        cmp("post_rst_low", act, exp_of(1'b0, 1'b0, 0));
        step(1'b1);
        cmp("post_rst_rise", act, exp_of(1'b1, 1'b0, 0));

        // Randomized lock waveforms, with occasional async resets.
        for (int seg = 0; seg < 250; seg++) begin
            bit lk;
            int len;
            lk  = ($urandom_range(0, 3) != 0);
            len = lk ? $urandom_range(1, 30) : $urandom_range(1, 4);
            for (int c = 0; c < len; c++) step(lk);
            if ($urandom_range(0, 39) == 0) async_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Consumer end of the PLL lock interface.
- Takes the raw asynchronous `locked` output of a PLL wrapper and produces a clean, synchronously-deasserted system reset in the PLL output clock domain.
- Deassertion requires lock to stay stable for a programmable time. Loss of lock re-asserts reset and is counted.
- Sits directly after the PLL instance at the top level and feeds every downstream block's reset.

Parameters:
- SYNC_STAGES, 2, flip-flop stages synchronizing pll_locked (legal 2..4).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before the hold phase (legal >=1).
- RESET_HOLD_CYCLES, 16, extra cycles sys_rst_n stays low after lock is deemed stable (legal >=1).
- LOSS_CNT_W, 8, width of the lock-loss counter.

Ports:
- clk  input  1  PLL output clock; the only clock.
- rst_n  input  1  asynchronous active-low reset (board/power-on).
- pll_locked  input  1  raw PLL lock; asynchronous to clk and may glitch.
- sys_rst_n  output  1  system reset, active-low. Asserts asynchronously on rst_n; deasserts synchronously to clk.
- ready  output  1  high exactly when state is RUN.
- lock_lost  output  1  sticky: set on any loss of lock in HOLD or RUN.
- lock_loss_count  output  LOSS_CNT_W  number of lock losses in HOLD or RUN; saturating.

Behaviour:
- Reset:
  - One clock (clk). rst_n is asynchronous active-low.
  - While rst_n=0: all synchronizer flops=0, state=WAIT_LOCK, counter=0, sys_rst_n=0, ready=0, lock_lost=0, lock_loss_count=0.
- Synchronizer: lock_s = pll_locked after SYNC_STAGES flops; no other logic samples pll_locked.
- FSM, registered, single down-counter cnt:
  - WAIT_LOCK: sys_rst_n=0. If lock_s=1: load cnt=LOCK_STABLE_CYCLES-1, go to STABLE.
  - STABLE: if lock_s=0, go to WAIT_LOCK (no count change). Else if cnt=0: load cnt=RESET_HOLD_CYCLES-1, go to HOLD. Else decrement cnt.
  - HOLD: if lock_s=0, go to WAIT_LOCK and register a loss. Else if cnt=0, go to RUN. Else decrement cnt.
  - RUN: sys_rst_n=1, ready=1. If lock_s=0, go to WAIT_LOCK and register a loss.
- Outputs:
  - sys_rst_n and ready are registered decodes of the next state.
  - sys_rst_n rises on the same edge the FSM enters RUN, and falls on the same edge it leaves RUN.
- Deassert latency: with pll_locked held high from before edge 0, sys_rst_n rises on edge SYNC_STAGES + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES. Edge 0 is the first edge sampling pll_locked=1.
- Reassert latency: pll_locked falling in RUN drops sys_rst_n on edge SYNC_STAGES after the first edge sampling 0.
- Glitch rule: any lock_s=0 cycle in STABLE/HOLD restarts the full sequence. Lock pulses shorter than one clk period may be missed; this is acceptable.
- Loss registration: lock_lost<=1; lock_loss_count increments and saturates at all-ones (no wrap). Loss of lock in STABLE is not counted: stability had not yet been established.
- rst_n asserted mid-sequence: immediate asynchronous return to reset values, including the counter and sticky flag.
- rst_n released: first edge behaves as WAIT_LOCK, with the synchronizer filled from zeros.

Optional Feature:
- Macro: PLL_RESET_SEQ_LOSS_STATS_EN.
- Defined: lock_lost and lock_loss_count are implemented as above.
- Undefined: both outputs are tied to 0 and no counter/flag flops exist. FSM, sys_rst_n and ready are unchanged.

Test Plan:
- Cold start. Params SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4; release rst_n, raise pll_locked before edge 0 -> sys_rst_n and ready low through edge 13, high on edge 14; lock_loss_count=0.
- Glitch in STABLE. Same params; pll_locked low for 1 cycle at edge 5 -> sequence restarts; sys_rst_n rises 14 edges after pll_locked is first resampled high; lock_lost=0.
- Loss in RUN. From RUN, drop pll_locked -> sys_rst_n low 2 edges after first low sample; lock_lost=1, count=1. Relock -> RUN again after 14 edges.
- Loss in HOLD. Drop pll_locked for 1 cycle during HOLD -> returns to WAIT_LOCK, count increments by 1, full 14-edge relock.
- Saturation. LOSS_CNT_W=2; 5 losses in RUN -> count reads 1,2,3,3,3.
- Async reset mid-RUN. Pulse rst_n low between clock edges -> sys_rst_n, ready, lock_lost and count go to 0 without a clock edge. Rebuild with the macro undefined -> lock_lost and count stay 0 throughout.
